// File: rtl/mf_trigger_sched.sv
// rtl/mf_trigger_sched.sv - matched-filter trigger scheduler with fill mask, holdoff and threshold sequencing
//
// Purpose:
//   Forms |x| for each sample of the filter's SSR output block and compares
//   it against the active threshold. The earliest sample above threshold in a
//   block raises a trigger. A holdoff/re-arm state machine gates further
//   triggers. The machine masks the filter pipeline fill after enable.
//   Pipeline: input register -> magnitude (S1) -> compare (S2) -> trigger.
//   Data sampled at edge t gives a trigger after edge t+3.
//
// Optional feature:
//   MF_TRIG_COUNT_EN - when defined, builds a saturating 32-bit trigger
//   counter. The counter clears on the IDLE->FILL transition. When the macro
//   is undefined, trig_cnt_o is tied to 0.
//
// Ports:
//   aclk          in   clock, rising edge
//   rst           in   synchronous active-high reset
//   en_i          in   scheduler enable
//   data_i        in   NSAMPS signed samples, sample i at [NBITS*i +: NBITS]
//   thresh_i      in   unsigned threshold value
//   thresh_wr_i   in   threshold write strobe
//   thresh_ack_o  out  high for one cycle after the write edge
//   holdoff_i     in   holdoff length, latched at each trigger
//   trig_o        out  single-cycle trigger pulse
//   trig_idx_o    out  sample index of the last trigger
//   trig_mag_o    out  magnitude of the last trigger
//   state_o       out  IDLE=0, FILL=1, ARMED=2, HOLDOFF=3
//   trig_cnt_o    out  trigger count (0 without MF_TRIG_COUNT_EN)

module mf_trigger_sched #(
  parameter int NBITS     = 18,
  parameter int NSAMPS    = 8,
  parameter int FILL_CLKS = 8,
  parameter int HOLDOFF_W = 16,
  parameter int IDXW      = $clog2(NSAMPS)
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [NBITS*NSAMPS-1:0]  data_i,
  input  logic [NBITS-1:0]         thresh_i,
  input  logic                     thresh_wr_i,
  output logic                     thresh_ack_o,
  input  logic [HOLDOFF_W-1:0]     holdoff_i,
  output logic                     trig_o,
  output logic [IDXW-1:0]          trig_idx_o,
  output logic [NBITS-1:0]         trig_mag_o,
  output logic [1:0]               state_o,
  output logic [31:0]              trig_cnt_o
);

  localparam int FILLW = $clog2(FILL_CLKS + 1);
  localparam int CNTW  = (HOLDOFF_W > FILLW) ? HOLDOFF_W : FILLW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_ARMED   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [CNTW-1:0]                r_cnt, w_cnt_nxt;
  logic                           w_fire;

  logic [NBITS*NSAMPS-1:0]        r_data;
  logic [NSAMPS-1:0][NBITS-1:0]   w_mag;
  logic [NSAMPS-1:0][NBITS-1:0]   r_s1_mag;
  logic [NSAMPS-1:0][NBITS-1:0]   r_s2_mag;
  logic [NSAMPS-1:0]              r_s2_hit;
  logic [NBITS-1:0]               r_thr;
  logic                           r_ack;

  logic                           w_any_hit;
  logic [IDXW-1:0]                w_sel_idx;
  logic [NBITS-1:0]               w_sel_mag;

  logic                           r_trig;
  logic [IDXW-1:0]                r_trig_idx;
  logic [NBITS-1:0]               r_trig_mag;

  // Two's-complement negate in NBITS bits. The most negative value maps to
  // 2^(NBITS-1). This is correct as an unsigned result, so no saturation is needed.
  always_comb begin
    w_mag = '0;
    for (int i = 0; i < NSAMPS; i++) begin
      if (r_data[NBITS*i + NBITS-1]) begin
        w_mag[i] = ~r_data[NBITS*i +: NBITS] + NBITS'(1);
      end else begin
        w_mag[i] = r_data[NBITS*i +: NBITS];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_data   <= '0;
      r_s1_mag <= '0;
      r_s2_mag <= '0;
      r_s2_hit <= '0;
    end else begin
      r_data   <= data_i;
      r_s1_mag <= w_mag;
      r_s2_mag <= r_s1_mag;
      // r_thr is used as registered, so a write on this edge affects only the next compare.
      for (int i = 0; i < NSAMPS; i++) begin
        r_s2_hit[i] <= (r_s1_mag[i] > r_thr);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_thr <= '1;
      r_ack <= 1'b0;
    end else begin
      r_ack <= thresh_wr_i;
      if (thresh_wr_i) begin
        r_thr <= thresh_i;
      end
    end
  end

  // Scanning downwards lets the lowest set index overwrite higher ones.
  always_comb begin
    w_any_hit = |r_s2_hit;
    w_sel_idx = '0;
    w_sel_mag = '0;
    for (int i = NSAMPS - 1; i >= 0; i--) begin
      if (r_s2_hit[i]) begin
        w_sel_idx = IDXW'(i);
        w_sel_mag = r_s2_mag[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The fill and holdoff phases never overlap, so they share one counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    if (!en_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = '0;
        end
        ST_FILL: begin
          if (r_cnt == CNTW'(FILL_CLKS - 1)) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
        ST_ARMED: begin
          if (w_any_hit) begin
            w_state_nxt = ST_HOLDOFF;
            w_cnt_nxt   = CNTW'(holdoff_i);
            w_fire      = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_cnt_nxt = r_cnt - CNTW'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_trig     <= 1'b0;
      r_trig_idx <= '0;
      r_trig_mag <= '0;
    end else begin
      r_trig <= w_fire;
      if (w_fire) begin
        r_trig_idx <= w_sel_idx;
        r_trig_mag <= w_sel_mag;
      end
    end
  end

`ifdef MF_TRIG_COUNT_EN
  logic [31:0] r_trig_cnt;

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_trig_cnt <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_FILL) begin
      r_trig_cnt <= '0;
    end else if (w_fire && r_trig_cnt != 32'hFFFF_FFFF) begin
      r_trig_cnt <= r_trig_cnt + 32'd1;
    end
  end

  assign trig_cnt_o = r_trig_cnt;
`else
  assign trig_cnt_o = '0;
`endif

  assign thresh_ack_o = r_ack;
  assign trig_o       = r_trig;
  assign trig_idx_o   = r_trig_idx;
  assign trig_mag_o   = r_trig_mag;
  assign state_o      = r_state;

endmodule
